vga_controlador: RTL and testbench

//  Timing generator and pattern sequencer for the 800x600@60Hz VGA output (40 MHz pixel clock).

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_controlador_contador.sv | 40 ++++
 rtl/vga_controlador.sv | 133 +++++++++++++
 tb/tb_vga_controlador.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : 800x600@60 timing constants, MODO encoding and FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int C_H_SYNC  = 128;
  localparam int C_H_BP    = 88;
  localparam int C_H_ACT   = 800;
  localparam int C_H_FP    = 40;
  localparam int C_V_SYNC  = 4;
  localparam int C_V_BP    = 23;
  localparam int C_V_ACT   = 600;
  localparam int C_V_FP    = 1;
  localparam int C_H_TOTAL = C_H_SYNC + C_H_BP + C_H_ACT + C_H_FP;
  localparam int C_V_TOTAL = C_V_SYNC + C_V_BP + C_V_ACT + C_V_FP;

  localparam int C_COL_W   = 11;
  localparam int C_FILA_W  = 10;
  localparam int C_MODO_W  = 2;
  localparam int C_N_MODOS = 4;

  typedef enum logic [C_MODO_W-1:0] {
    MODO_BARRAS     = 2'd0,
    MODO_CUADRICULA = 2'd1,
    MODO_DEGRADADO  = 2'd2,
    MODO_NEGRO      = 2'd3
  } modo_e;

  typedef enum logic {
    REPOSO    = 1'b0,
    PENDIENTE = 1'b1
  } estado_e;

  function automatic modo_e modo_siguiente(input modo_e m);
    if (m == modo_e'(C_N_MODOS - 1)) return MODO_BARRAS;
    return modo_e'(m + C_MODO_W'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_controlador_contador.sv
// ============================================================================
// contador_mod : modulo-N counter with enable, next-value and terminal count
// Rev 1.0
// ============================================================================
`default_nettype none

module contador_mod #(
  parameter int N     = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == WIDTH'(N - 1)) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign tc_o       = (cnt_q == WIDTH'(N - 1));

endmodule

`default_nettype wire

// File: rtl/vga_controlador.sv
// ============================================================================
// vga_controlador : VGA sync/blank timing generator and frame-locked MODO selector
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_controlador
  import vga_pkg::*;
#(
  parameter int H_SYNC = vga_pkg::C_H_SYNC,
  parameter int H_BP   = vga_pkg::C_H_BP,
  parameter int H_ACT  = vga_pkg::C_H_ACT,
  parameter int H_FP   = vga_pkg::C_H_FP,
  parameter int V_SYNC = vga_pkg::C_V_SYNC,
  parameter int V_BP   = vga_pkg::C_V_BP,
  parameter int V_ACT  = vga_pkg::C_V_ACT,
  parameter int V_FP   = vga_pkg::C_V_FP
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                boton_i,
  output logic [C_COL_W-1:0]  columna_o,
  output logic [C_FILA_W-1:0] fila_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                blank_n_o,
  output logic                fin_frame_o,
  output logic [C_MODO_W-1:0] modo_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [C_COL_W-1:0]  HS_FIN = C_COL_W'(H_SYNC);
  localparam logic [C_COL_W-1:0]  HA_INI = C_COL_W'(H_SYNC + H_BP);
  localparam logic [C_COL_W-1:0]  HA_FIN = C_COL_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [C_COL_W-1:0]  H_ULT  = C_COL_W'(H_TOTAL - 1);
  localparam logic [C_FILA_W-1:0] VS_FIN = C_FILA_W'(V_SYNC);
  localparam logic [C_FILA_W-1:0] VA_INI = C_FILA_W'(V_SYNC + V_BP);
  localparam logic [C_FILA_W-1:0] VA_FIN = C_FILA_W'(V_SYNC + V_BP + V_ACT);

  logic [C_COL_W-1:0]  col_q;
  logic [C_COL_W-1:0]  col_d;
  logic [C_FILA_W-1:0] fila_q;
  logic [C_FILA_W-1:0] fila_d;
  logic                col_tc;
  logic                fila_tc;

  contador_mod #(.N(H_TOTAL), .WIDTH(C_COL_W)) u_cnt_col (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (1'b1),
    .cnt_o      (col_q),
    .cnt_next_o (col_d),
    .tc_o       (col_tc)
  );

  contador_mod #(.N(V_TOTAL), .WIDTH(C_FILA_W)) u_cnt_fila (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (col_tc),
    .cnt_o      (fila_q),
    .cnt_next_o (fila_d),
    .tc_o       (fila_tc)
  );

  logic hsync_q;
  logic vsync_q;
  logic blank_n_q;
  logic fin_frame_q;

  // Flags are computed from the counters' next values so they land on the
  // same edge as the position they describe. The row cannot change while the
  // column moves onto its last value, so the current row terminal count holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      blank_n_q   <= 1'b0;
      fin_frame_q <= 1'b0;
    end else begin
      hsync_q     <= (col_d < HS_FIN);
      vsync_q     <= (fila_d < VS_FIN);
      blank_n_q   <= (col_d >= HA_INI) && (col_d < HA_FIN) &&
                     (fila_d >= VA_INI) && (fila_d < VA_FIN);
      fin_frame_q <= (col_d == H_ULT) && fila_tc;
    end
  end

  estado_e estado_q;
  modo_e   modo_q;
  logic    boton_prev_q;
  logic    flanco;

  assign flanco = boton_i & ~boton_prev_q;

  // A rising edge seen during the FIN_FRAME cycle is honoured at that boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q     <= REPOSO;
      modo_q       <= MODO_BARRAS;
      boton_prev_q <= 1'b0;
    end else begin
      boton_prev_q <= boton_i;
      case (estado_q)
        REPOSO: begin
          if (flanco) begin
            if (fin_frame_q) modo_q   <= modo_siguiente(modo_q);
            else             estado_q <= PENDIENTE;
          end
        end
        PENDIENTE: begin
          if (fin_frame_q) begin
            modo_q   <= modo_siguiente(modo_q);
            estado_q <= REPOSO;
          end
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

  assign columna_o   = col_q;
  assign fila_o      = fila_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign blank_n_o   = blank_n_q;
  assign fin_frame_o = fin_frame_q;
  assign modo_o      = modo_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_controlador.sv
// ============================================================================
// tb_vga_controlador : directed bench; full-size timing plus a reduced-timing
// instance for whole-frame and MODO sequencing. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_controlador;

  localparam int AHS = 128, AHB = 88, AHA = 800, AVS = 4, AVB = 23, AVA = 600;
  localparam int AHT = 1056, AVT = 628;
  localparam int BHS = 4, BHB = 3, BHA = 8, BHF = 2, BVS = 2, BVB = 2, BVA = 5, BVF = 1;
  localparam int BHT = 17, BVT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boton = 1'b0;

  logic [10:0] col_a, col_b;
  logic [9:0]  fila_a, fila_b;
  logic        hs_a, vs_a, bl_a, fin_a, hs_b, vs_b, bl_b, fin_b;
  logic [1:0]  modo_a, modo_b;

  vga_controlador dut_a (
    .clk_i(clk), .rst_i(rst), .boton_i(boton),
    .columna_o(col_a), .fila_o(fila_a), .hsync_o(hs_a), .vsync_o(vs_a),
    .blank_n_o(bl_a), .fin_frame_o(fin_a), .modo_o(modo_a)
  );

  vga_controlador #(
    .H_SYNC(BHS), .H_BP(BHB), .H_ACT(BHA), .H_FP(BHF),
    .V_SYNC(BVS), .V_BP(BVB), .V_ACT(BVA), .V_FP(BVF)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .boton_i(boton),
    .columna_o(col_b), .fila_o(fila_b), .hsync_o(hs_b), .vsync_o(vs_b),
    .blank_n_o(bl_b), .fin_frame_o(fin_b), .modo_o(modo_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int mc_a = 0, mr_a = 0, mc_b = 0, mr_b = 0;
  bit m_rst = 1'b1;
  logic [1:0] emodo_b = 2'd0;
  int c_hs_a, c_vs_a, c_bl_a, c_hs_b, c_vs_b, c_bl_b, c_fin_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] expv(input int c, input int r,
      input int hs, input int hb, input int ha, input int ht,
      input int vs, input int vb, input int va, input int vt,
      input logic [1:0] m, input bit in_rst);
    logic h, v, b, f;
    if (in_rst) return '0;
    h = (c < hs);
    v = (r < vs);
    b = (c >= hs + hb) && (c < hs + hb + ha) && (r >= vs + vb) && (r < vs + vb + va);
    f = (c == ht - 1) && (r == vt - 1);
    return {11'(c), 10'(r), h, v, b, f, m};
  endfunction

  task automatic clear_counts();
    c_hs_a = 0; c_vs_a = 0; c_bl_a = 0;
    c_hs_b = 0; c_vs_b = 0; c_bl_b = 0; c_fin_b = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rst = 1'b1;
      mc_a = 0; mr_a = 0; mc_b = 0; mr_b = 0;
    end else begin
      m_rst = 1'b0;
      if (mc_a == AHT - 1) begin mc_a = 0; mr_a = (mr_a == AVT - 1) ? 0 : mr_a + 1; end
      else mc_a++;
      if (mc_b == BHT - 1) begin mc_b = 0; mr_b = (mr_b == BVT - 1) ? 0 : mr_b + 1; end
      else mc_b++;
    end
    @(negedge clk);
    check("pos_flags_a", {5'd0, col_a, fila_a, hs_a, vs_a, bl_a, fin_a, modo_a},
          {5'd0, expv(mc_a, mr_a, AHS, AHB, AHA, AHT, AVS, AVB, AVA, AVT, 2'd0, m_rst)});
    check("pos_flags_b", {5'd0, col_b, fila_b, hs_b, vs_b, bl_b, fin_b, modo_b},
          {5'd0, expv(mc_b, mr_b, BHS, BHB, BHA, BHT, BVS, BVB, BVA, BVT, emodo_b, m_rst)});
    c_hs_a += int'(hs_a); c_vs_a += int'(vs_a); c_bl_a += int'(bl_a);
    c_hs_b += int'(hs_b); c_vs_b += int'(vs_b); c_bl_b += int'(bl_b); c_fin_b += int'(fin_b);
  endtask

  task automatic run_to_b(input int c, input int r);
    int k;
    k = 0;
    while (!(mc_b == c && mr_b == r) && k < 400) begin
      tick();
      k++;
    end
    if (!(mc_b == c && mr_b == r)) begin
      n_cmp++;
      n_err++;
      $error("FAIL run_to_b: observed timeout at (%0d,%0d) expected (%0d,%0d)", mc_b, mr_b, c, r);
    end
  endtask

  task automatic press();
    boton = 1'b1;
    tick();
    boton = 1'b0;
    tick();
  endtask

  initial begin
    int k;

    // Reset state
    repeat (3) tick();
    check("reset_all_a", {col_a, fila_a, hs_a, vs_a, bl_a, fin_a, modo_a}, 32'd0);
    check("reset_all_b", {col_b, fila_b, hs_b, vs_b, bl_b, fin_b, modo_b}, 32'd0);

    // Release: first visible position is (1,0)
    rst = 1'b0;
    clear_counts();
    tick();
    check("first_col_a", col_a, 32'd1);
    check("first_fila_a", fila_a, 32'd0);
    repeat (AHT - 1) tick();
    check("wrap_col_a", col_a, 32'd0);
    check("wrap_fila_a", fila_a, 32'd1);
    check("hsync_cnt_line", c_hs_a, 32'd128);

    // Continue to (1055,29): rows 0..3 vsync, rows 27..29 active
    repeat (30 * AHT - 1 - AHT) tick();
    check("end_col_a", col_a, 32'd1055);
    check("end_fila_a", fila_a, 32'd29);
    check("vsync_cnt_a", c_vs_a, 32'd4223);
    check("blank_cnt_a", c_bl_a, 32'd2400);
    check("hsync_cnt_a", c_hs_a, 32'd3839);

    // Reduced-timing whole frame: spacing, counts, FIN_FRAME position
    run_to_b(BHT - 1, BVT - 1);
    check("fin_at_last_b", fin_b, 32'd1);
    clear_counts();
    k = 0;
    do begin
      tick();
      k++;
    end while (!fin_b && k < 400);
    check("fin_spacing_b", k, 32'd170);
    check("fin_pos_b", {col_b, fila_b}, {5'd0, 11'd16, 10'd9});
    check("fin_cnt_b", c_fin_b, 32'd1);
    check("blank_cnt_b", c_bl_b, 32'd40);
    check("hsync_cnt_b", c_hs_b, 32'd40);
    check("vsync_cnt_b", c_vs_b, 32'd34);

    // Single mid-frame press: advance only after FIN_FRAME
    tick();
    run_to_b(5, 3);
    press();
    run_to_b(BHT - 1, BVT - 1);
    check("modo_hold_b", modo_b, 32'd0);
    emodo_b = 2'd1;
    tick();
    check("modo_adv1_b", modo_b, 32'd1);

    // Three presses in one frame: one advance
    run_to_b(2, 2);
    press();
    run_to_b(5, 4);
    press();
    run_to_b(9, 6);
    press();
    run_to_b(BHT - 1, BVT - 1);
    emodo_b = 2'd2;
    tick();
    check("modo_three_b", modo_b, 32'd2);
    run_to_b(BHT - 1, BVT - 1);
    tick();
    check("modo_idle_b", modo_b, 32'd2);

    // Held high: one advance, no repeat
    run_to_b(3, 3);
    boton = 1'b1;
    run_to_b(BHT - 1, BVT - 1);
    emodo_b = 2'd3;
    tick();
    run_to_b(BHT - 1, BVT - 1);
    tick();
    check("modo_held_b", modo_b, 32'd3);
    boton = 1'b0;

    // Wrap 3 -> 0
    run_to_b(4, 4);
    press();
    run_to_b(BHT - 1, BVT - 1);
    emodo_b = 2'd0;
    tick();
    check("modo_wrap_b", modo_b, 32'd0);

    // Press coincident with FIN_FRAME counts for that boundary
    run_to_b(BHT - 1, BVT - 1);
    boton = 1'b1;
    emodo_b = 2'd1;
    tick();
    boton = 1'b0;
    check("modo_coinc_b", modo_b, 32'd1);
    tick();

    // Mid-frame reset with a pending press: everything clears
    run_to_b(2, 2);
    press();
    run_to_b(8, 5);
    rst = 1'b1;
    emodo_b = 2'd0;
    tick();
    check("midrst_b", {col_b, fila_b, hs_b, vs_b, bl_b, fin_b, modo_b}, 32'd0);
    check("midrst_a", {col_a, fila_a, hs_a, vs_a, bl_a, fin_a, modo_a}, 32'd0);
    rst = 1'b0;
    clear_counts();
    repeat (168) tick();
    check("no_fin_after_rst", c_fin_b, 32'd0);
    tick();
    check("fin_after_rst", fin_b, 32'd1);
    tick();
    check("pending_cleared", modo_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
